// File: rtl/l8_pkg.sv
// Shared constants and FSM state encoding for the l8 fill/drain memory controller.
package l8_pkg;
  localparam int M          = 16;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, DONE} state_t;
endpackage

// File: rtl/l8_skid_fifo.sv
// Two-entry skid FIFO that catches read data returning from the memory one cycle after issue.
module l8_skid_fifo
  import l8_pkg::*;
#(
  parameter int WIDTH = M * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             not_empty
);

  logic [WIDTH-1:0] slot_p0 [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != 2'd0);
  assign do_pop    = pop & not_empty;
  assign do_push   = push & ((count != 2'd2) | do_pop);
  assign pop_data  = slot_p0[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slot_p0[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l8_mem_ctrl.sv
// Frame controller: fills an external memory from a write stream, then replays it
// cfg_passes times to a read stream through a 2-entry skid buffer.
module l8_mem_ctrl #(
  parameter int M          = l8_pkg::M,
  parameter int ADDR_WIDTH = l8_pkg::ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            cfg_words,
  input  logic [3:0]                       cfg_passes,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [M*l8_pkg::DATA_WIDTH-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [M*l8_pkg::DATA_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr1,
  output logic [ADDR_WIDTH-1:0]            mem_addr2,
  output logic                             mem_wr,
  output logic [M*l8_pkg::DATA_WIDTH-1:0]  mem_q,
  input  logic [M*l8_pkg::DATA_WIDTH-1:0]  mem_out,
  output logic                             busy,
  output logic                             done
);

  import l8_pkg::*;

  localparam int DW = M * DATA_WIDTH;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] words_m1;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [3:0]            passes_m1;
  logic [3:0]            pass_cnt;
  logic                  vld_p1;
  logic [1:0]            occ;
  logic [2:0]            committed;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  wrap;
  logic                  last_wr;
  logic                  last_rd;

  assign in_ready  = (state == FILL);
  assign accept    = in_ready & in_valid;
  assign mem_wr    = accept;
  assign mem_addr1 = in_ready ? wr_cnt : '0;
  assign mem_q     = in_data;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Occupancy is taken after this cycle's pop so a full-rate consumer keeps one read per cycle.
  assign pop       = out_valid & out_ready;
  assign committed = {1'b0, occ} - {2'b00, pop} + {2'b00, vld_p1};
  assign issue     = (state == DRAIN) && (committed < 3'd2);
  assign mem_addr2 = (state == DRAIN) ? rd_cnt : '0;

  assign wrap      = (rd_cnt == words_m1);
  assign last_rd   = issue & wrap & (pass_cnt == passes_m1);
  assign last_wr   = accept & (wr_cnt == words_m1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FILL;
      FILL:    if (last_wr) state_nx = DRAIN;
      DRAIN:   if (last_rd) state_nx = FLUSH;
      FLUSH:   if (!vld_p1 && !out_valid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0 -> p1: issue bookkeeping; vld_p1 marks read data arriving on mem_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      words_m1  <= '0;
      passes_m1 <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      pass_cnt  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= issue;
      if (state == IDLE && start) begin
        // A zero count wraps to all-ones, which encodes the maximum size.
        words_m1  <= cfg_words - ADDR_WIDTH'(1);
        passes_m1 <= cfg_passes - 4'(1);
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        pass_cnt  <= '0;
      end
      if (accept) wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
      if (issue) begin
        if (wrap) begin
          rd_cnt   <= '0;
          pass_cnt <= pass_cnt + 4'(1);
        end else begin
          rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

  l8_skid_fifo #(
    .WIDTH(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (vld_p1),
    .push_data(mem_out),
    .pop      (pop),
    .pop_data (out_data),
    .count    (occ),
    .not_empty(out_valid)
  );

endmodule
